ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer.sv | 158 +++++++++++++++
 tb/tb_ctrl_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ctrl_sequencer                                                   |
// | Purpose : Multi-cycle fetch/execute/memory/writeback control sequencer     |
// |           for a 9-bit instruction processor with cycle accounting.         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ctrl_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [8:0]  InstIn,
  input  logic        MemReady,
  input  logic        AluOverflow,
  output logic [7:0]  InstAddr,
  output logic [3:0]  OP,
  output logic [2:0]  RegAddrA,
  output logic [2:0]  RegAddrB,
  output logic        RegWrEn,
  output logic        RegWrSrcMem,
  output logic        MemRdEn,
  output logic        MemWrEn,
  output logic        OverflowFlag,
  output logic        Done,
  output logic [15:0] CycleCount
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_HALTED = 3'd5;

  localparam logic [3:0] c_OP_ADD   = 4'b0000;
  localparam logic [3:0] c_OP_SUB   = 4'b0001;
  localparam logic [3:0] c_OP_LOAD  = 4'b0010;
  localparam logic [3:0] c_OP_STORE = 4'b0011;
  localparam logic [3:0] c_OP_RST   = 4'b1010;
  localparam logic [3:0] c_OP_HALT  = 4'b1011;

  localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

  logic [2:0]  r_state;
  logic [7:0]  r_pc;
  logic [8:0]  r_ir;
  logic        r_overflow;
  logic [15:0] r_cycleCount;

  logic [3:0]  w_opcode;
  logic        w_isMemOp;
  logic        w_busy;
  logic        w_updatesFlag;

  assign w_opcode      = r_ir[8:5];
  assign w_isMemOp     = (w_opcode == c_OP_LOAD) || (w_opcode == c_OP_STORE);
  assign w_busy        = (r_state == c_FETCH) || (r_state == c_EXEC) ||
                         (r_state == c_MEM)   || (r_state == c_WB);
  assign w_updatesFlag = (w_opcode == c_OP_ADD) || (w_opcode == c_OP_SUB) ||
                         (w_opcode == c_OP_RST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= c_IDLE;
      r_pc         <= 8'd0;
      r_ir         <= 9'd0;
      r_overflow   <= 1'b0;
      r_cycleCount <= 16'd0;
    end else begin
      if (w_busy && (r_cycleCount != c_COUNT_MAX)) begin
        r_cycleCount <= r_cycleCount + 16'd1;
      end

      case (r_state)
        c_IDLE, c_HALTED: begin
          if (Start) begin
            r_state      <= c_FETCH;
            r_pc         <= 8'd0;
            r_cycleCount <= 16'd0;
            r_overflow   <= 1'b0;
          end
        end
        c_FETCH: begin
          r_ir    <= InstIn;
          r_state <= c_EXEC;
        end
        c_EXEC: begin
          if (w_updatesFlag) begin
            r_overflow <= AluOverflow;
          end
          if (w_opcode == c_OP_HALT) begin
            r_state <= c_HALTED;
          end else if (w_isMemOp) begin
            r_state <= c_MEM;
          end else begin
            r_pc    <= r_pc + 8'd1;
            r_state <= c_FETCH;
          end
        end
        c_MEM: begin
          // Wait indefinitely for the data memory handshake.
          if (MemReady) begin
            if (w_opcode == c_OP_LOAD) begin
              r_state <= c_WB;
            end else begin
              r_pc    <= r_pc + 8'd1;
              r_state <= c_FETCH;
            end
          end
        end
        c_WB: begin
          r_pc    <= r_pc + 8'd1;
          r_state <= c_FETCH;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Strobes are masked while Reset is high so an in-flight access drops at once.
  always_comb begin
    OP          = c_OP_HALT;
    RegWrEn     = 1'b0;
    RegWrSrcMem = 1'b0;
    MemRdEn     = 1'b0;
    MemWrEn     = 1'b0;
    if (!Reset) begin
      case (r_state)
        c_EXEC: begin
          OP      = w_opcode;
          RegWrEn = (w_opcode != c_OP_HALT) && !w_isMemOp && (w_opcode != c_OP_RST);
        end
        c_MEM: begin
          OP      = w_opcode;
          MemRdEn = (w_opcode == c_OP_LOAD);
          MemWrEn = (w_opcode == c_OP_STORE);
        end
        c_WB: begin
          OP          = w_opcode;
          RegWrEn     = 1'b1;
          RegWrSrcMem = 1'b1;
        end
        default: begin
          OP = c_OP_HALT;
        end
      endcase
    end
  end

  assign InstAddr     = r_pc;
  assign RegAddrA     = r_ir[4:2];
  assign RegAddrB     = {1'b0, r_ir[1:0]};
  assign OverflowFlag = r_overflow;
  assign CycleCount   = r_cycleCount;
  assign Done         = !Reset && (r_state == c_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ctrl_sequencer                                                |
// | Purpose : Randomized program runs against an instruction-level trace model. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`define CHK(n, a, e) chk(n, 32'(a), 32'(e))
module tb_ctrl_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [8:0]  InstIn;
    logic        MemReady;
    logic        AluOverflow;
    logic [7:0]  InstAddr;
    logic [3:0]  OP;
    logic [2:0]  RegAddrA;
    logic [2:0]  RegAddrB;
    logic        RegWrEn;
    logic        RegWrSrcMem;
    logic        MemRdEn;
    logic        MemWrEn;
    logic        OverflowFlag;
    logic        Done;
    logic [15:0] CycleCount;

    ctrl_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InstIn(InstIn),
        .MemReady(MemReady), .AluOverflow(AluOverflow), .InstAddr(InstAddr),
        .OP(OP), .RegAddrA(RegAddrA), .RegAddrB(RegAddrB), .RegWrEn(RegWrEn),
        .RegWrSrcMem(RegWrSrcMem), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
        .OverflowFlag(OverflowFlag), .Done(Done), .CycleCount(CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [8:0] rom [256];
    assign InstIn = rom[InstAddr];

    typedef struct {
        bit          start, memReady, aluOv;
        logic [7:0]  addr;
        logic [3:0]  op;
        logic [2:0]  ra, rb;
        bit          regWr, srcMem, rdEn, wrEn, done, ovf;
        logic [15:0] cnt;
    } cyc_t;

    cyc_t        trace[$];
    logic [7:0]  mPc;
    logic [8:0]  mIr;
    bit          mOvf;
    logic [15:0] mCnt;
    bit          mHalted;
    bit          prevHalted;

    int checks = 0;
    int errors = 0;
    int rdSeen, wbSeen, wrapSeen;
    logic [7:0] lastAddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void addCyc(input logic [3:0] op, input bit rw, input bit sm,
                                   input bit rd, input bit wr, input bit dn,
                                   input bit mr, input bit ao);
        cyc_t c;
        c.start    = dn ? 1'b0 : ($urandom_range(0, 7) == 0);
        c.memReady = mr;
        c.aluOv    = ao;
        c.addr     = mPc;
        c.op       = op;
        c.ra       = mIr[4:2];
        c.rb       = {1'b0, mIr[1:0]};
        c.regWr    = rw;
        c.srcMem   = sm;
        c.rdEn     = rd;
        c.wrEn     = wr;
        c.done     = dn;
        c.ovf      = mOvf;
        c.cnt      = mCnt;
        trace.push_back(c);
        if (!dn) mCnt = (mCnt == 16'hFFFF) ? 16'hFFFF : mCnt + 16'd1;
    endfunction

    function automatic void buildRun(input int maxCycles, input int forcedWait, input bit ovfMode);
        logic [3:0] op;
        bit ao;
        int w;
        trace.delete();
        mPc = 8'd0; mCnt = 16'd0; mOvf = 1'b0; mHalted = 1'b0;
        while (trace.size() < maxCycles && !mHalted) begin
            addCyc(4'hB, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            mIr = rom[mPc];
            op  = mIr[8:5];
            ao  = ovfMode ? (op == 4'h0) : 1'($urandom_range(0, 1));
            if (op == 4'hB) begin
                addCyc(op, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), ao);
                mHalted = 1'b1;
            end else if (op == 4'h2 || op == 4'h3) begin
                addCyc(op, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)), ao);
                w = (forcedWait >= 0) ? forcedWait : int'($urandom_range(0, 3));
                for (int k = 0; k <= w; k++)
                    addCyc(op, 0, 0, op == 4'h2, op == 4'h3, 0, k == w, 1'($urandom_range(0, 1)));
                if (op == 4'h2) addCyc(op, 1, 1, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                mPc = mPc + 8'd1;
            end else begin
                addCyc(op, op != 4'hA, 0, 0, 0, 0, 1'($urandom_range(0, 1)), ao);
                if (op == 4'h0 || op == 4'h1 || op == 4'hA) mOvf = ao;
                mPc = mPc + 8'd1;
            end
        end
        if (mHalted) begin
            for (int k = 0; k < 3; k++)
                addCyc(4'hB, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end else begin
            while (trace.size() > maxCycles) void'(trace.pop_back());
        end
    endfunction

    task automatic startRun();
        Start = 1'b1; MemReady = 1'($urandom_range(0, 1)); AluOverflow = 1'($urandom_range(0, 1));
        @(negedge Clk);
        `CHK("done_before_start", Done, prevHalted);
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic playTrace();
        rdSeen = 0; wbSeen = 0;
        for (int i = 0; i < trace.size(); i++) begin
            Start = trace[i].start; MemReady = trace[i].memReady; AluOverflow = trace[i].aluOv;
            @(negedge Clk);
            if (i == 0) begin
                checks += 2;
                if (InstAddr !== 8'd0) begin
                    errors++;
                    $display("FAIL restart_pc: got %0h at %0t", InstAddr, $time);
                end
                if (CycleCount !== 16'd0) begin
                    errors++;
                    $display("FAIL restart_count: got %0h at %0t", CycleCount, $time);
                end
            end
            checks += 12;
            if (InstAddr !== trace[i].addr) begin
                errors++;
                $display("FAIL InstAddr: got %0h expected %0h at %0t", InstAddr, trace[i].addr, $time);
            end
            if (OP !== trace[i].op) begin
                errors++;
                $display("FAIL OP: got %0h expected %0h at %0t", OP, trace[i].op, $time);
            end
            if (RegAddrA !== trace[i].ra) begin
                errors++;
                $display("FAIL RegAddrA: got %0h expected %0h at %0t", RegAddrA, trace[i].ra, $time);
            end
            if (RegAddrB !== trace[i].rb) begin
                errors++;
                $display("FAIL RegAddrB: got %0h expected %0h at %0t", RegAddrB, trace[i].rb, $time);
            end
            if (RegWrEn !== trace[i].regWr) begin
                errors++;
                $display("FAIL RegWrEn: got %0h expected %0h at %0t", RegWrEn, trace[i].regWr, $time);
            end
            if (RegWrSrcMem !== trace[i].srcMem) begin
                errors++;
                $display("FAIL RegWrSrcMem: got %0h expected %0h at %0t", RegWrSrcMem, trace[i].srcMem, $time);
            end
            if (MemRdEn !== trace[i].rdEn) begin
                errors++;
                $display("FAIL MemRdEn: got %0h expected %0h at %0t", MemRdEn, trace[i].rdEn, $time);
            end
            if (MemWrEn !== trace[i].wrEn) begin
                errors++;
                $display("FAIL MemWrEn: got %0h expected %0h at %0t", MemWrEn, trace[i].wrEn, $time);
            end
            if (OverflowFlag !== trace[i].ovf) begin
                errors++;
                $display("FAIL OverflowFlag: got %0h expected %0h at %0t", OverflowFlag, trace[i].ovf, $time);
            end
            if (Done !== trace[i].done) begin
                errors++;
                $display("FAIL Done: got %0h expected %0h at %0t", Done, trace[i].done, $time);
            end
            if (CycleCount !== trace[i].cnt) begin
                errors++;
                $display("FAIL CycleCount: got %0h expected %0h at %0t", CycleCount, trace[i].cnt, $time);
            end
            if ((32'(RegWrEn) + 32'(MemRdEn) + 32'(MemWrEn)) > 32'd1) begin
                errors++;
                $display("FAIL strobe_exclusive at %0t", $time);
            end
            if (MemRdEn) rdSeen++;
            if (RegWrSrcMem) wbSeen++;
            if (lastAddr == 8'd255 && InstAddr == 8'd0) wrapSeen++;
            lastAddr = InstAddr;
            @(posedge Clk); #1;
        end
        Start = 1'b0;
        prevHalted = mHalted;
    endtask

    task automatic applyReset();
        Reset = 1'b1; Start = 1'b1; MemReady = 1'b1; AluOverflow = 1'b1;
        @(negedge Clk);
        `CHK("rst_during_RegWrEn", RegWrEn, 1'b0);
        `CHK("rst_during_MemRdEn", MemRdEn, 1'b0);
        `CHK("rst_during_MemWrEn", MemWrEn, 1'b0);
        `CHK("rst_during_OP", OP, 4'hB);
        @(posedge Clk); #1;
        Reset = 1'b0; Start = 1'b0;
        @(negedge Clk);
        `CHK("rst_Done", Done, 1'b0);
        `CHK("rst_CycleCount", CycleCount, 16'd0);
        `CHK("rst_InstAddr", InstAddr, 8'd0);
        `CHK("rst_Overflow", OverflowFlag, 1'b0);
        `CHK("rst_OP", OP, 4'hB);
        `CHK("rst_MemWrEn", MemWrEn, 1'b0);
        `CHK("rst_RegWrEn", RegWrEn, 1'b0);
        `CHK("rst_RegAddrA", RegAddrA, 3'd0);
        `CHK("rst_RegAddrB", RegAddrB, 3'd0);
        @(posedge Clk); #1;
        mIr = 9'd0;
        prevHalted = 1'b0;
    endtask

    task automatic loadProgram(input logic [8:0] p0, input logic [8:0] p1,
                               input logic [8:0] p2, input logic [8:0] p3);
        for (int i = 0; i < 256; i++) rom[i] = 9'b1011_00000;
        rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
    endtask

    initial begin
        int maxC;
        logic [3:0] op;
        Reset = 1'b1; Start = 1'b0; MemReady = 1'b0; AluOverflow = 1'b0;
        mIr = 9'd0; prevHalted = 1'b0; wrapSeen = 0; lastAddr = 8'd0;
        for (int i = 0; i < 256; i++) rom[i] = 9'd0;
        @(posedge Clk); #1;
        applyReset();

        loadProgram(9'b0000_001_10, 9'b1011_00000, 9'b1011_00000, 9'b1011_00000);
        buildRun(1000, -1, 1'b0);
        `CHK("model_len_addhalt", trace.size(), 7);
        `CHK("model_add_regwr", trace[1].regWr, 1'b1);
        startRun(); playTrace();
        `CHK("addhalt_count", CycleCount, 16'd4);
        `CHK("addhalt_pc", InstAddr, 8'd1);
        `CHK("addhalt_done", Done, 1'b1);

        loadProgram(9'b0010_001_01, 9'b1011_00000, 9'b1011_00000, 9'b1011_00000);
        buildRun(1000, 3, 1'b0);
        startRun(); playTrace();
        `CHK("load_rd_cycles", rdSeen, 4);
        `CHK("load_wb_cycles", wbSeen, 1);
        `CHK("load_pc", InstAddr, 8'd1);
        `CHK("load_count", CycleCount, 16'd9);

        loadProgram(9'b0000_010_11, 9'b0100_011_00, 9'b1011_00000, 9'b1011_00000);
        buildRun(1000, -1, 1'b1);
        startRun(); playTrace();
        `CHK("ovf_after_nand", OverflowFlag, 1'b1);
        loadProgram(9'b0000_010_11, 9'b0100_011_00, 9'b1010_000_00, 9'b1011_00000);
        buildRun(1000, -1, 1'b1);
        startRun(); playTrace();
        `CHK("ovf_after_rst", OverflowFlag, 1'b0);

        loadProgram(9'b0011_010_11, 9'b1011_00000, 9'b1011_00000, 9'b1011_00000);
        buildRun(4, 3, 1'b0);
        startRun(); playTrace();
        `CHK("store_wr_pending", MemWrEn, 1'b1);
        applyReset();

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 256; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hB) op = 4'h4;
                rom[i] = {op, 5'($urandom_range(0, 31))};
            end
            rom[$urandom_range(2, 20)] = 9'b1011_00000;
            maxC = (r % 4 == 3) ? int'($urandom_range(3, 25)) : 1000;
            buildRun(maxC, -1, 1'b0);
            startRun(); playTrace();
            if (!mHalted) applyReset();
        end

        for (int i = 0; i < 256; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hB) op = 4'h5;
            rom[i] = {op, 5'($urandom_range(0, 31))};
        end
        wrapSeen = 0;
        buildRun(65600, -1, 1'b0);
        startRun(); playTrace();
        `CHK("count_saturated", CycleCount, 16'hFFFF);
        `CHK("pc_wrapped", wrapSeen != 0, 1'b1);
        applyReset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
